// File: rtl/tea_sequencer.sv
// -----------------------------------------------------------------------------
// tea_sequencer
//
// Control FSM for an iterative TEA (Tiny Encryption Algorithm) datapath. It
// issues one datapath strobe per clock, covering the five sub-steps of each
// TEA round, repeated ROUNDS times. It runs encrypt and decrypt orderings.
//
// Parameters
//   ROUNDS     TEA rounds per operation, legal range 1..63.
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   resetn     asynchronous active-low reset
//   start      operation request, sampled only in IDLE
//   decrypt    mode for the requested operation (1 = decrypt), sampled with start
//   abort      cancels any operation in progress (returns to IDLE, no done)
//   hold       (TEA_SEQ_STALL_EN builds only) freezes state and round and
//              suppresses all datapath strobes while high
//   busy       high in INIT and in every round state
//   done       one-cycle completion pulse (DONE state)
//   dec        latched mode, driven to the datapath
//   sum_init   datapath clears sum (dec=0) or loads delta*ROUNDS (dec=1)
//   ld_sum     sum update strobe (SUM for encrypt, DSUM for decrypt)
//   ld_res1    first half-round result strobe
//   ld_upd1    first half-round word update strobe
//   ld_res2    second half-round result strobe
//   ld_upd2    second half-round word update strobe
//   round      number of completed rounds
//
// Build option
//   TEA_SEQ_STALL_EN  when defined, adds the hold input. When undefined, the
//                     FSM free-runs and the block has no hold port.
// -----------------------------------------------------------------------------
module tea_sequencer #(
  parameter int ROUNDS = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       decrypt,
  input  logic       abort,
`ifdef TEA_SEQ_STALL_EN
  input  logic       hold,
`endif
  output logic       busy,
  output logic       done,
  output logic       dec,
  output logic       sum_init,
  output logic       ld_sum,
  output logic       ld_res1,
  output logic       ld_upd1,
  output logic       ld_res2,
  output logic       ld_upd2,
  output logic [5:0] round
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_INIT = 4'd1,
    S_SUM  = 4'd2,
    S_RES1 = 4'd3,
    S_UPD1 = 4'd4,
    S_RES2 = 4'd5,
    S_UPD2 = 4'd6,
    S_DSUM = 4'd7,
    S_DONE = 4'd8
  } state_t;

  // The round that, once completed, finishes the operation. Comparing the
  // current count against ROUNDS-1 avoids a 7-bit round+1 adder in the compare.
  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  state_t     state_q, state_d;
  logic [5:0] round_q, round_d;
  logic       dec_q,   dec_d;
  logic       stall;

`ifdef TEA_SEQ_STALL_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  // First state of every round: encrypt updates sum before the half-rounds,
  // decrypt uses the preloaded sum first and decrements it at the end.
  function automatic state_t round_entry(input logic mode);
    return mode ? S_RES1 : S_SUM;
  endfunction

  // Encodings 9..15 are unreachable; they must not be allowed to persist,
  // not even while hold is high.
  function automatic logic state_is_legal(input state_t s);
    logic legal;
    case (s)
      S_IDLE, S_INIT, S_SUM, S_RES1, S_UPD1,
      S_RES2, S_UPD2, S_DSUM, S_DONE: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

  // ---------------------------------------------------------------------------
  // State, round counter and latched mode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    dec_d   = dec_q;

    case (state_q)
      S_IDLE: begin
        // abort wins over start in IDLE: the request is simply dropped.
        if (start && !abort) begin
          dec_d   = decrypt;
          round_d = '0;
          state_d = S_INIT;
        end
      end
      S_INIT: state_d = round_entry(dec_q);
      S_SUM:  state_d = S_RES1;
      S_RES1: state_d = S_UPD1;
      S_UPD1: state_d = S_RES2;
      S_RES2: state_d = S_UPD2;
      S_UPD2: begin
        if (dec_q) begin
          state_d = S_DSUM;
        end else begin
          round_d = round_q + 6'd1;
          state_d = (round_q == LAST_ROUND) ? S_DONE : round_entry(dec_q);
        end
      end
      S_DSUM: begin
        round_d = round_q + 6'd1;
        state_d = (round_q == LAST_ROUND) ? S_DONE : round_entry(dec_q);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // hold freezes everything, including acceptance of start in IDLE, but an
    // illegal encoding still recovers on the next edge.
    if (stall && state_is_legal(state_q)) begin
      state_d = state_q;
      round_d = round_q;
      dec_d   = dec_q;
    end

    // abort overrides hold; the round count is left as it was so the datapath
    // owner can see how far the cancelled operation had progressed.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      round_d = round_q;
      dec_d   = dec_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs: decoded from the state only; hold masks the strobes but
  // leaves busy and done visible.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    sum_init = 1'b0;
    ld_sum   = 1'b0;
    ld_res1  = 1'b0;
    ld_upd1  = 1'b0;
    ld_res2  = 1'b0;
    ld_upd2  = 1'b0;

    case (state_q)
      S_INIT: begin
        busy     = 1'b1;
        sum_init = !stall;
      end
      S_SUM: begin
        busy   = 1'b1;
        ld_sum = !stall;
      end
      S_RES1: begin
        busy    = 1'b1;
        ld_res1 = !stall;
      end
      S_UPD1: begin
        busy    = 1'b1;
        ld_upd1 = !stall;
      end
      S_RES2: begin
        busy    = 1'b1;
        ld_res2 = !stall;
      end
      S_UPD2: begin
        busy    = 1'b1;
        ld_upd2 = !stall;
      end
      S_DSUM: begin
        busy   = 1'b1;
        ld_sum = !stall;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign dec   = dec_q;
  assign round = round_q;

endmodule

// File: tb/tb_tea_sequencer.sv
module tb_tea_sequencer;

  localparam int R = 32;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       decrypt;
  logic       abort;
`ifdef TEA_SEQ_STALL_EN
  logic       hold;
`endif
  logic       busy, done, dec;
  logic       sum_init, ld_sum, ld_res1, ld_upd1, ld_res2, ld_upd2;
  logic [5:0] round;

  int errors = 0;
  int checks = 0;

  wire [5:0] strb = {sum_init, ld_sum, ld_res1, ld_upd1, ld_res2, ld_upd2};

  tea_sequencer #(.ROUNDS(R)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .decrypt  (decrypt),
    .abort    (abort),
`ifdef TEA_SEQ_STALL_EN
    .hold     (hold),
`endif
    .busy     (busy),
    .done     (done),
    .dec      (dec),
    .sum_init (sum_init),
    .ld_sum   (ld_sum),
    .ld_res1  (ld_res1),
    .ld_upd1  (ld_upd1),
    .ld_res2  (ld_res2),
    .ld_upd2  (ld_upd2),
    .round    (round)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference strobe pattern for edge k (k = 1..5*R) after the start edge.
  // Bit order: {sum_init, ld_sum, ld_res1, ld_upd1, ld_res2, ld_upd2}.
  function automatic logic [5:0] exp_strb(input logic mode, input int k);
    int p;
    logic [5:0] v;
    p = (k - 1) % 5;
    v = 6'b000000;
    if (!mode) begin
      case (p)
        0: v = 6'b010000;
        1: v = 6'b001000;
        2: v = 6'b000100;
        3: v = 6'b000010;
        default: v = 6'b000001;
      endcase
    end else begin
      case (p)
        0: v = 6'b001000;
        1: v = 6'b000100;
        2: v = 6'b000010;
        3: v = 6'b000001;
        default: v = 6'b010000;
      endcase
    end
    return v;
  endfunction

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; decrypt = 1'b0; abort = 1'b0;
`ifdef TEA_SEQ_STALL_EN
    hold = 1'b0;
`endif
    tick();
    checks++;
    if ({busy, done, dec, strb, round} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b dec=%b strb=%b round=%0d, want all 0",
               busy, done, dec, strb, round);
    end
    #4 resetn = 1'b1;
    tick();
    checks++;
    if ({busy, done, strb, round} !== 14'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b done=%b strb=%b round=%0d, want idle",
               busy, done, strb, round);
    end
  endtask

  // Full operation in the given mode, checked edge by edge against the model.
  task automatic test_operation(input logic mode);
    int nsum;
    int ndone;
    logic [5:0] first_s, last_s;
    nsum = 0; ndone = 0; first_s = '0; last_s = '0;
    start = 1'b1; decrypt = mode;
    tick();                               // edge 0
    start = 1'b0; decrypt = ~mode;
    checks++;
    if (strb !== 6'b100000 || busy !== 1'b1 || dec !== mode || round !== 6'd0) begin
      errors++;
      $display("FAIL op%0d_init: got strb=%b busy=%b dec=%b round=%0d, want 100000 1 %b 0",
               mode, strb, busy, dec, round, mode);
    end
    for (int k = 1; k <= 5 * R + 2; k++) begin
      tick();
      if (ld_sum) nsum++;
      if (done) ndone++;
      if (k == 1) first_s = strb;
      if (k == 5 * R) last_s = strb;
      checks++;
      if (k <= 5 * R) begin
        if (strb !== exp_strb(mode, k) || busy !== 1'b1 || done !== 1'b0 ||
            round !== 6'((k - 1) / 5) || dec !== mode) begin
          errors++;
          $display("FAIL op%0d_edge%0d: got strb=%b busy=%b done=%b round=%0d dec=%b, want strb=%b busy=1 done=0 round=%0d dec=%b",
                   mode, k, strb, busy, done, round, dec, exp_strb(mode, k), (k - 1) / 5, mode);
        end
      end else if (k == 5 * R + 1) begin
        if (done !== 1'b1 || busy !== 1'b0 || strb !== 6'd0 || round !== 6'(R) || dec !== mode) begin
          errors++;
          $display("FAIL op%0d_done_edge%0d: got done=%b busy=%b strb=%b round=%0d dec=%b, want done=1 busy=0 strb=0 round=%0d dec=%b",
                   mode, k, done, busy, strb, round, dec, R, mode);
        end
      end else begin
        if (done !== 1'b0 || busy !== 1'b0 || strb !== 6'd0 || round !== 6'(R)) begin
          errors++;
          $display("FAIL op%0d_idle_after: got done=%b busy=%b strb=%b round=%0d, want 0 0 0 %0d",
                   mode, done, busy, strb, round, R);
        end
      end
    end
    checks++;
    if (nsum !== R || ndone !== 1) begin
      errors++;
      $display("FAIL op%0d_counts: got ld_sum=%0d done_pulses=%0d, want %0d 1", mode, nsum, ndone, R);
    end
    checks++;
    if (first_s !== (mode ? 6'b001000 : 6'b010000) || last_s !== (mode ? 6'b010000 : 6'b000001)) begin
      errors++;
      $display("FAIL op%0d_first_last: got first=%b last=%b", mode, first_s, last_s);
    end
  endtask

  task automatic test_abort();
    start = 1'b1; decrypt = 1'b0;
    tick();                               // edge 0
    start = 1'b0;
    for (int k = 1; k <= 49; k++) tick();
    abort = 1'b1;
    tick();                               // edge 50
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || strb !== 6'd0 || done !== 1'b0 || round !== 6'd9) begin
      errors++;
      $display("FAIL abort_now: got busy=%b strb=%b done=%b round=%0d, want 0 0 0 9",
               busy, strb, done, round);
    end
    for (int k = 51; k <= 60; k++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || strb !== 6'd0 || done !== 1'b0 || round !== 6'd9) begin
        errors++;
        $display("FAIL abort_edge%0d: got busy=%b strb=%b done=%b round=%0d, want 0 0 0 9",
                 k, busy, strb, done, round);
      end
    end
    start = 1'b1; decrypt = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (round !== 6'd0 || dec !== 1'b1 || sum_init !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart: got round=%0d dec=%b sum_init=%b busy=%b, want 0 1 1 1",
               round, dec, sum_init, busy);
    end
    abort = 1'b1;                         // abort straight out of INIT
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || strb !== 6'd0 || round !== 6'd0) begin
      errors++;
      $display("FAIL abort_init: got busy=%b strb=%b round=%0d, want 0 0 0", busy, strb, round);
    end
  endtask

  task automatic test_abort_priority();
    start = 1'b1; abort = 1'b1; decrypt = 1'b0;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || sum_init !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_priority: got busy=%b sum_init=%b done=%b, want 0 0 0", busy, sum_init, done);
    end
  endtask

  task automatic test_start_held();
    int ndone;
    ndone = 0;
    start = 1'b1;
    for (int k = 0; k < 200; k++) begin
      decrypt = k[0];
      tick();
      if (k <= 162 && done) ndone++;
      if (k >= 1 && k <= 5 * R + 1) begin
        checks++;
        if (dec !== 1'b0) begin
          errors++;
          $display("FAIL held_dec_edge%0d: got dec=%b, want 0", k, dec);
        end
      end
      if (k == 5 * R + 2) begin
        checks++;
        if (busy !== 1'b0 || sum_init !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL held_idle: got busy=%b sum_init=%b done=%b, want 0 0 0", busy, sum_init, done);
        end
      end
      if (k == 5 * R + 3) begin
        checks++;
        if (busy !== 1'b1 || sum_init !== 1'b1 || dec !== 1'b1 || round !== 6'd0) begin
          errors++;
          $display("FAIL held_second_start: got busy=%b sum_init=%b dec=%b round=%0d, want 1 1 1 0",
                   busy, sum_init, dec, round);
        end
      end
      if (k > 5 * R + 3) begin
        checks++;
        if (dec !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL held_second_dec_edge%0d: got dec=%b busy=%b, want 1 1", k, dec, busy);
        end
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL held_done_count: got %0d, want 1", ndone);
    end
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    start = 1'b1; decrypt = 1'b1;
    tick();                               // edge 0
    start = 1'b0;
    for (int k = 1; k <= 80; k++) tick();
    checks++;
    if (busy !== 1'b1 || dec !== 1'b1 || round !== 6'd15) begin
      errors++;
      $display("FAIL pre_reset: got busy=%b dec=%b round=%0d, want 1 1 15", busy, dec, round);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({busy, done, dec, strb, round} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b dec=%b strb=%b round=%0d, want all 0",
               busy, done, dec, strb, round);
    end
    #2 resetn = 1'b1;
    start = 1'b1; decrypt = 1'b0;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || sum_init !== 1'b1 || dec !== 1'b0) begin
      errors++;
      $display("FAIL reset_resume: got busy=%b sum_init=%b dec=%b, want 1 1 0", busy, sum_init, dec);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

`ifdef TEA_SEQ_STALL_EN
  task automatic test_hold();
    int done_edge;
    done_edge = -1;
    start = 1'b1; decrypt = 1'b0;
    tick();                               // edge 0
    start = 1'b0;
    for (int k = 1; k <= 175; k++) begin
      if (k == 20) hold = 1'b1;
      tick();
      if (done && done_edge < 0) done_edge = k;
      if (hold) begin
        checks++;
        if (strb !== 6'd0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL hold_edge%0d: got strb=%b busy=%b, want 000000 1", k, strb, busy);
        end
      end
      if (k == 29) hold = 1'b0;
    end
    checks++;
    if (done_edge !== 5 * R + 11) begin
      errors++;
      $display("FAIL hold_done_edge: got %0d, want %0d", done_edge, 5 * R + 11);
    end
    checks++;
    if (round !== 6'(R)) begin
      errors++;
      $display("FAIL hold_round: got %0d, want %0d", round, R);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_operation(1'b0);
    test_operation(1'b1);
    test_abort();
    test_abort_priority();
    test_start_held();
    test_async_reset();
`ifdef TEA_SEQ_STALL_EN
    test_hold();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
